// File: rtl/start_ctrl.sv
// start_ctrl: turns a debounced button level into start strobes with auto-repeat,
// a one-deep press buffer, and issued/dropped command counters.
module start_ctrl #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             db_in,
    input  logic             done,
    output logic             start,
    output logic             busy,
    output logic             pending,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int MAX_C = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW = $clog2(MAX_C);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state_q, state_d;
    logic             db_q;
    logic             armed_q, armed_d, long_q, long_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             start_q, start_d, busy_q, busy_d, pending_q, pending_d;
    logic [CNT_W-1:0] issue_q, issue_d, drop_q, drop_d;
    logic             press, rep, ev, stash;

    always_comb begin
        press   = db_in & ~db_q;
        rep     = armed_q & db_in & (hold_q == (long_q ? REP_LAST : HOLD_LAST));
        ev      = press | rep;
        armed_d = armed_q;
        long_d  = long_q;
        hold_d  = hold_q;
        if (!db_in) begin
            armed_d = 1'b0;
            long_d  = 1'b0;
            hold_d  = '0;
        end else if (press) begin
            armed_d = 1'b1;
            long_d  = 1'b0;
            hold_d  = '0;
        end else if (rep) begin
            long_d = 1'b1;
            hold_d = '0;
        end else if (armed_q) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        stash     = 1'b0;
        case (state_q)
            IDLE:  state_d = ev ? ISSUE : IDLE;
            ISSUE: begin
                state_d = WAIT;
                stash   = ev;
            end
            WAIT: begin
                if (done && pending_q) begin
                    // the buffered press issues now; a coincident event takes its slot
                    state_d   = ISSUE;
                    pending_d = ev;
                end else if (done) begin
                    state_d = ev ? ISSUE : IDLE;
                end else begin
                    stash = ev;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stash && pending_q)
            drop_d = (&drop_q) ? drop_q : drop_q + CNT_W'(1);
        else if (stash)
            pending_d = 1'b1;
        issue_d = issue_q + CNT_W'(state_d == ISSUE);
        start_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            db_q      <= 1'b1;
            armed_q   <= 1'b0;
            long_q    <= 1'b0;
            hold_q    <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            issue_q   <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_in;
            armed_q   <= armed_d;
            long_q    <= long_d;
            hold_q    <= hold_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
            issue_q   <= issue_d;
            drop_q    <= drop_d;
        end
    end

    assign start     = start_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign issue_cnt = issue_q;
    assign drop_cnt  = drop_q;
endmodule

// File: doc/start_ctrl.md
# start_ctrl

Press-to-command controller that sits directly downstream of the push-button debouncer. It turns the debounced button level into single-cycle `start` commands for the processing core, with auto-repeat on long press. It runs a start/done handshake with the core and buffers at most one press that arrives while the core is busy. It also keeps an issued-command count and a dropped-press count for the display path.

## Interface
Parameters:
- HOLD_CYCLES, 50_000_000: cycles a press must be held before the first auto-repeat event (1 s at 50 MHz); legal minimum 2.
- REPEAT_CYCLES, 12_500_000: cycles between subsequent auto-repeat events while held; legal minimum 2.
- CNT_W, 8: width of `issue_cnt` and `drop_cnt`.

Ports:
- clk, input, 1: single system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-low reset; applies all reset values immediately.
- db_in, input, 1: debounced button level from the debouncer (`db_out`); 1 = pressed.
- done, input, 1: one-cycle completion strobe from the processing core.
- start, output, 1: one-cycle command strobe to the core; registered.
- busy, output, 1: high from the `start` cycle until the cycle `done` is accepted; registered.
- pending, output, 1: one press is buffered; registered.
- issue_cnt, output, CNT_W: number of `start` strobes issued; wraps modulo 2^CNT_W.
- drop_cnt, output, CNT_W: number of presses discarded because the buffer was full; saturates at all-ones.

## Operation
- Reset values: start=0, busy=0, pending=0, issue_cnt=0, drop_cnt=0, state=IDLE. Internal: db_q=1, armed=0, long=0, hold_cnt=0.
- Edge detect: `db_q <= db_in`. The `press` condition is `db_in & ~db_q`. Because db_q resets to 1, a button held through reset release produces no event; the operator must release and press again.
- Hold timer:
  - `press` sets armed=1, long=0, hold_cnt=0.
  - While armed and db_in=1, hold_cnt increments each cycle.
  - With long=0, when hold_cnt reaches HOLD_CYCLES-1, assert `rep` for one cycle, then set long=1 and hold_cnt=0.
  - With long=1, when hold_cnt reaches REPEAT_CYCLES-1, assert `rep` for one cycle and set hold_cnt=0.
  - db_in=0 clears armed, long and hold_cnt in the same cycle.
- Event: `ev = press | rep`. `press` and `rep` are never both true.
- FSM, three states:
  - IDLE: on `ev`, go to ISSUE. With no `ev`, stay in IDLE.
  - ISSUE: `start`=1 and busy=1 for exactly one cycle, then go to WAIT. issue_cnt increments on entry to ISSUE. `done` is ignored in this state.
  - WAIT: busy=1. On `done`, if pending=1 or `ev` is true, go to ISSUE and clear pending. If neither, go to IDLE.
- Buffering: an `ev` in ISSUE, or an `ev` in WAIT without `done`, sets pending=1 if pending was 0. If pending was already 1, the event is discarded and drop_cnt increments (saturating).
- Simultaneous `done` and `ev` in WAIT while pending=1: issue the pending command. The new `ev` becomes the pending one, so pending stays 1 and nothing is dropped.
- `done` in IDLE is ignored and has no side effects.
- The pending flag is only consumed on `done`; IDLE is never entered while pending=1.

## Timing
- If db_in is first sampled high at edge E0, `ev` is combinationally true in the cycle before E0. `start` is high in the cycle after E0, so latency is 1 clock.
- busy rises in the same cycle as `start`. It falls in the cycle after the edge that samples `done` in WAIT, unless the FSM re-enters ISSUE.
- Back-to-back: with `done` in WAIT and pending=1, the next `start` is 1 cycle after `done`. busy stays high with no gap.
- First repeat: `rep` occurs HOLD_CYCLES cycles after the press event. Each following repeat is spaced REPEAT_CYCLES cycles from the previous one.
- Asynchronous reset mid-operation (ISSUE/WAIT, pending set, timer running) forces all reset values at once; the buffered press is lost. After release, the first `start` requires a fresh 0→1 on db_in.

## Test plan
- Reset with db_in=1, release rst, hold db_in=1 for 20 cycles (HOLD_CYCLES=8, REPEAT_CYCLES=4) -> start never asserts; issue_cnt=0.
- db_in 0→1 at edge E0, `done` returned 3 cycles after `start` -> `start` high only in cycle E0+1; busy high for 4 cycles; issue_cnt=1; state returns to IDLE.
- HOLD_CYCLES=8, REPEAT_CYCLES=4; press held 20 cycles, `done` returned 1 cycle after each `start` -> 4 strobes: press at cycle 0, repeats at cycles 8, 12, 16; issue_cnt=4.
- Three presses during one WAIT (each press 3 cycles high, 3 cycles low) -> pending=1 after the first press, drop_cnt=2. `done` -> `start` follows 1 cycle later, busy stays high continuously, pending=0.
- `done` and a new press in the same WAIT cycle with pending=1 -> `start` next cycle, pending stays 1, drop_cnt unchanged.
- CNT_W=2: 5 issued commands -> issue_cnt=1. 5 dropped presses -> drop_cnt=3. Assert rst in WAIT -> all outputs 0 in the same cycle.
